// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the register-specified shift sequencer: shift codes,
// FSM state encodings and the shift-amount load rule.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [5:0] REM_SAT = 6'd33;

    // Linear shifts saturate at 33 so the 32nd step produces the ARM carry and the
    // extra step clears it; ROR only cares about the amount mod 32.
    function automatic logic [5:0] calc_rem(input logic [1:0] sh, input logic [7:0] amount);
        logic [5:0] r;
        if (sh == SH_ROR) begin
            r = {1'b0, amount[4:0]};
            if (amount != 8'd0 && amount[4:0] == 5'd0) r = 6'd32;
        end else begin
            r = (amount > 8'd33) ? REM_SAT : amount[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts data by k (0..STEP) and returns
// the ARM-style carry-out of that step; k=0 passes data and carry through.
module shift_step
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] data,
    input  logic [5:0]  k,
    input  logic [1:0]  sh,
    input  logic        cin,
    output logic [31:0] data_o,
    output logic        cout
);

    logic [32:0]        lsl_t;
    logic [32:0]        lsr_t;
    logic signed [32:0] asr_t;
    logic [31:0]        ror_t;

    // A guard bit beside the data word catches the last bit shifted out.
    always_comb begin
        lsl_t = {1'b0, data} << k;
        lsr_t = {data, 1'b0} >> k;
        asr_t = $signed({data, 1'b0}) >>> k;
        ror_t = (data >> k) | (data << (6'd32 - k));
    end

    always_comb begin
        data_o = data;
        cout   = cin;
        if (k != 6'd0) begin
            unique case (sh)
                SH_LSL: begin data_o = lsl_t[31:0];  cout = lsl_t[32]; end
                SH_LSR: begin data_o = lsr_t[32:1];  cout = lsr_t[0];  end
                SH_ASR: begin data_o = asr_t[32:1];  cout = asr_t[0];  end
                SH_ROR: begin data_o = ror_t;        cout = ror_t[31]; end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for register-specified shifts: iterates a step shifter
// at most STEP bits per cycle and hands back an ARM-exact result and carry.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand,
    input  logic [1:0]  sh,
    input  logic [7:0]  amount,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [5:0] STEP_K = 6'(STEP);

    state_e      state_q;
    logic [5:0]  rem_q;
    logic [31:0] data_q;
    logic        cy_q;
    logic [1:0]  sh_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] result_q;
    logic        carry_out_q;

    logic [5:0]  k_d;
    logic [5:0]  rem_d;
    logic [5:0]  rem_ld_d;
    logic [31:0] step_data;
    logic        step_cy;

    always_comb begin
        k_d      = (rem_q < STEP_K) ? rem_q : STEP_K;
        rem_d    = rem_q - k_d;
        rem_ld_d = calc_rem(sh, amount);
    end

    shift_step u_step (
        .data   (data_q),
        .k      (k_d),
        .sh     (sh_q),
        .cin    (cy_q),
        .data_o (step_data),
        .cout   (step_cy)
    );

    // Outputs are captured only on entry to DONE, so flush leaves the last
    // delivered result on the bus rather than a partial shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= 6'd0;
            data_q      <= 32'd0;
            cy_q        <= 1'b0;
            sh_q        <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            carry_out_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            rem_q       <= 6'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q     <= operand;
                        sh_q       <= sh;
                        cy_q       <= carry_in;
                        rem_q      <= rem_ld_d;
                        in_ready_q <= 1'b0;
                        if (rem_ld_d == 6'd0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= operand;
                            carry_out_q <= carry_in;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data;
                    cy_q   <= step_cy;
                    rem_q  <= rem_d;
                    if (rem_d == 6'd0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= step_data;
                        carry_out_q <= step_cy;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (STEP=4): directed ops push expected
// result/carry/latency; a negedge monitor checks every presented result.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [1:0]  sh;
    logic [7:0]  amount;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;

    shift_sequencer #(.STEP(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .sh        (sh),
        .amount    (amount),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cy;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    logic flush_e = 1'b0;
    bit   tmo = 1'b0;
    bit   done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) flush_e <= flush;

    task automatic send(input logic [31:0] op, input logic [1:0] s, input logic [7:0] a,
                        input logic ci, input logic [31:0] er, input logic ec,
                        input int el, input bit push);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        operand  = op;
        sh       = s;
        amount   = a;
        carry_in = ci;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) begin
            e.res = er; e.cy = ec; e.lat = el; e.acc = cyc;
            q.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        if (q.size() != 0) tmo = 1'b1;
    endtask

    // Monitor: the only process that steps the comparison counters.
    bit seen = 1'b0;
    int seen_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("drain_queue_empty", 32'(q.size()), 32'd0);
            chk("no_timeout", {31'd0, tmo}, 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end else if (!reset_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_carry", {31'd0, carry_out}, 32'd0);
        end else begin
            if (in_ready && out_valid) chk("ready_valid_exclusive", 32'd1, 32'd0);
            if (flush_e) begin
                chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
                chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    seen_cyc = cyc;
                end
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("result", result, q[0].res);
                    chk("carry_out", {31'd0, carry_out}, {31'd0, q[0].cy});
                    chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        chk("latency", 32'(seen_cyc - q[0].acc), 32'(q[0].lat));
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operand   = 32'd0;
        sh        = 2'b00;
        amount    = 8'd0;
        carry_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        //    operand        sh     amt   cin   result         cy   lat
        send(32'h0000_0001, 2'b00, 8'd4,   1'b0, 32'h0000_0010, 1'b0, 2,  1'b1);
        send(32'h8000_0000, 2'b01, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9,  1'b1);
        send(32'h8000_0000, 2'b01, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 10, 1'b1);
        send(32'h8000_0000, 2'b10, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 10, 1'b1);
        send(32'h8000_0001, 2'b11, 8'd64,  1'b0, 32'h8000_0001, 1'b1, 9,  1'b1);
        send(32'h0000_0001, 2'b11, 8'd4,   1'b1, 32'h1000_0000, 1'b0, 2,  1'b1);
        send(32'h0000_0001, 2'b00, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9,  1'b1);
        send(32'h7000_0000, 2'b10, 8'd3,   1'b1, 32'h0E00_0000, 1'b0, 2,  1'b1);
        send(32'h0000_00F0, 2'b01, 8'd5,   1'b0, 32'h0000_0007, 1'b1, 3,  1'b1);
        send(32'h1234_5678, 2'b11, 8'd36,  1'b0, 32'h8123_4567, 1'b1, 2,  1'b1);
        send(32'h0000_0003, 2'b00, 8'd6,   1'b0, 32'h0000_00C0, 1'b0, 3,  1'b1);
        drain();

        // Amount zero under back-pressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'hDEAD_BEEF, 2'b01, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 1'b1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Flush during SHIFT, then flush in IDLE with a competing request
        send(32'hFFFF_FFFF, 2'b00, 8'd32, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(posedge clk);
        #1 begin
            flush    = 1'b1;
            in_valid = 1'b1;
            operand  = 32'h0000_0005;
            sh       = 2'b00;
            amount   = 8'd0;
        end
        @(posedge clk);
        #1 begin
            flush    = 1'b0;
            in_valid = 1'b0;
        end
        send(32'h8000_0000, 2'b00, 8'd1, 1'b0, 32'h0000_0000, 1'b1, 2, 1'b1);
        drain();

        // Asynchronous reset mid-SHIFT
        send(32'hFFFF_FFFF, 2'b00, 8'd32, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        send(32'hF000_0000, 2'b10, 8'd8, 1'b0, 32'hFFF0_0000, 1'b0, 3, 1'b1);
        drain();

        @(posedge clk);
        done = 1'b1;
    end

endmodule
